// File: rtl/oci_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : oci_trace_pkg
//  Purpose  : Shared types and constants for the OCI trace capture buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package oci_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        ENDED   = 2'd3
    } trace_state_t;

    localparam int MODE_STOP = 0;
    localparam int MODE_WRAP = 1;

endpackage
`default_nettype wire

// File: rtl/oci_trace_ram.sv
`default_nettype none
// ============================================================================
//  Module   : oci_trace_ram
//  Purpose  : DEPTH x DATA_W register array, synchronous write, async read.
//  Revision : 1.0 - initial release
// ============================================================================
module oci_trace_ram #(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/nios_oci_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module   : nios_oci_trace_capture
//  Purpose  : OCI trace word capture buffer with FWFT readout and end-of-test drain.
//  Revision : 1.0 - initial release
// ============================================================================
module nios_oci_trace_capture
    import oci_trace_pkg::*;
#(
    parameter int  DATA_W    = 30,
    parameter int  DEPTH     = 16,
    parameter int  WRAP_MODE = 0,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              trace_valid,
    input  logic [DATA_W-1:0] trace_data,
    output logic              trace_ready,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  dct_count,
    output logic              overflow,
    input  logic              test_ending,
    output logic              test_has_ended
);

    localparam int ADDR_W = $clog2(DEPTH);

    trace_state_t      r_state;
    trace_state_t      w_state_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_in_capture;
    logic w_push;
    logic w_pop;
    logic w_evict;
    logic w_drop;

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_in_capture = (r_state == CAPTURE);

    assign trace_ready = w_in_capture && ((WRAP_MODE == MODE_WRAP) || !w_full);
    assign w_push      = trace_valid && trace_ready;
    assign w_pop       = rd_ready && !w_empty;
    // Only reachable in wrap mode: a push into a full buffer displaces the oldest word.
    assign w_evict     = w_push && w_full && !w_pop;
    assign w_drop      = w_in_capture && trace_valid && !trace_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (test_ending) begin
                    w_state_next = DRAIN;
                end else if (enable) begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (test_ending) begin
                    w_state_next = DRAIN;
                end else if (!enable) begin
                    w_state_next = IDLE;
                end
            end
            DRAIN: begin
                if (w_empty) begin
                    w_state_next = ENDED;
                end
            end
            default: w_state_next = ENDED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop || w_evict) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_push && !w_pop && !w_full) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_evict || w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    oci_trace_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (w_push),
        .waddr  (r_wr_ptr),
        .wdata  (trace_data),
        .raddr  (r_rd_ptr),
        .rdata  (rd_data)
    );

    assign rd_valid       = !w_empty;
    assign dct_count      = r_count;
    assign overflow       = r_overflow;
    assign test_has_ended = (r_state == ENDED);

endmodule
`default_nettype wire
